// File: rtl/conv_stream_controller.sv
// Sequences one convolutional layer: steps the layer once per accepted pixel, detects
// pixels that complete a stride-aligned window and parks the layer result in a one-deep output slot.
module conv_stream_controller #(
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int Q_BUS_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   layer_clk_en,
  input  logic [Q_BUS_WIDTH-1:0] layer_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [Q_BUS_WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic [1:0]             dbg_state
);

  localparam int CW   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WPD  = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int NWIN = WPD * WPD;
  localparam int NW   = $clog2(NWIN + 1);

  localparam logic [CW-1:0] LAST_IDX  = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] WIN_START = CW'(FILTER_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);
  localparam logic [NW-1:0] LAST_WIN  = NW'(NWIN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          col_q, row_q;
  logic [PW-1:0]          col_ph_q, row_ph_q;
  logic [NW-1:0]          win_cnt_q;
  logic                   pend_q;
  logic                   m_valid_q;
  logic                   m_last_q;
  logic                   frame_done_q;
  logic [Q_BUS_WIDTH-1:0] m_data_q;

  logic accept;
  logic col_wrap;
  logic last_pixel;
  logic win_hit;
  logic capture;
  logic m_hs;
  logic pend_d;
  logic m_valid_d;

  // Valid/ready: a transfer happens on any rising edge where valid and ready are both high;
  // the producer holds data stable while valid is high and not yet accepted.
  assign s_ready      = (state_q == RUN) && !(pend_q && m_valid_q && !m_ready);
  assign accept       = s_valid && s_ready;
  assign layer_clk_en = accept;

  // Phase counters hold (pos - FILTER_SIZE + 1) mod STRIDE once pos reaches the window start.
  assign col_wrap   = (col_q == LAST_IDX);
  assign last_pixel = col_wrap && (row_q == LAST_IDX);
  assign win_hit    = (row_q >= WIN_START) && (col_q >= WIN_START) &&
                      (row_ph_q == '0) && (col_ph_q == '0);

  assign capture   = pend_q && (!m_valid_q || m_ready);
  assign m_hs      = m_valid_q && m_ready;
  assign pend_d    = (accept && win_hit) || (pend_q && !capture);
  assign m_valid_d = capture || (m_valid_q && !m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      win_cnt_q    <= '0;
      pend_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      pend_q       <= pend_d;
      m_valid_q    <= m_valid_d;

      if (capture) begin
        m_data_q  <= layer_data;
        m_last_q  <= (win_cnt_q == LAST_WIN);
        win_cnt_q <= win_cnt_q + 1'b1;
      end else if (m_hs) begin
        m_last_q <= 1'b0;
      end

      if (accept) begin
        if (col_wrap) begin
          col_q    <= '0;
          col_ph_q <= '0;
          row_q    <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
          row_ph_q <= (row_q < WIN_START || row_ph_q == PH_LAST) ? '0 : row_ph_q + 1'b1;
        end else begin
          col_q    <= col_q + 1'b1;
          col_ph_q <= (col_q < WIN_START || col_ph_q == PH_LAST) ? '0 : col_ph_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            col_q     <= '0;
            row_q     <= '0;
            col_ph_q  <= '0;
            row_ph_q  <= '0;
            win_cnt_q <= '0;
          end
        end
        RUN: begin
          if (accept && last_pixel) state_q <= DRAIN;
        end
        DRAIN: begin
          // Leave on the edge that empties both slots so busy falls with frame_done.
          if (!pend_d && !m_valid_d) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/conv_stream_controller.md
# conv_stream_controller

Sequencer for one convolutional layer instance: accepts a raster-order pixel stream on a valid/ready handshake, drives the layer's `clk_en` one pulse per accepted pixel, and decides which pixel completes a valid FILTER_SIZE x FILTER_SIZE window at the configured STRIDE. For each such window it captures the layer's combinational output into a one-entry output register presented on a valid/ready handshake, so a stalled consumer backpressures the pixel source. Sits between the frame source and the next layer or pooling stage, one instance per convolutional layer.

## Interface
- IMAGE_SIZE, 28, input frame width = height in pixels
- FILTER_SIZE, 5, kernel edge length; 1 <= FILTER_SIZE <= IMAGE_SIZE
- STRIDE, 1, window step in both dimensions; >= 1
- Q_BUS_WIDTH, 64, width of the layer output bus (Q_WIDTH*Q_CHANNELS)
- clk  in  1  single clock; all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle frame start; honoured only in IDLE
- s_valid  in  1  source pixel valid
- s_ready  out  1  controller accepts a pixel this cycle
- layer_clk_en  out  1  `clk_en` to the layer; = s_valid && s_ready (combinational)
- layer_data  in  Q_BUS_WIDTH  layer output bus (combinational from its buffers)
- m_valid  out  1  output window valid
- m_ready  in  1  consumer accepts the window
- m_data  out  Q_BUS_WIDTH  registered window result
- m_last  out  1  qualifies the final window of the frame
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the frame has fully drained

## Operation
- States: IDLE -> RUN on start; RUN -> DRAIN on acceptance of pixel IMAGE_SIZE^2-1; DRAIN -> IDLE when pend=0 and m_valid=0, pulsing frame_done in that transition cycle.
- Counters col, row (ceil-log2(IMAGE_SIZE) bits) cleared on start; col increments per accepted pixel and wraps at IMAGE_SIZE-1, with row incrementing on the wrap.
- Window test on the accepted pixel (row, col): row >= F-1, col >= F-1, (row-F+1) % STRIDE == 0 and (col-F+1) % STRIDE == 0. Implement the modulo with stride-phase counters, not dividers.
- When the accepted pixel passes the window test, set pend at that edge; the layer output for that window is valid on layer_data from the next cycle.
- Capture: when pend && (!m_valid || m_ready), load m_data <= layer_data, set m_valid, and clear pend, unless a new qualifying pixel is accepted in the same cycle, in which case pend stays set.
- s_ready = (state==RUN) && !(pend && m_valid && !m_ready). The layer buffer never shifts while an uncaptured window is pending.
- m_valid clears on m_valid && m_ready with no capture in that cycle.
- m_last is set with the capture of window number W-1, where W = ((IMAGE_SIZE-F)/STRIDE+1)^2. It clears with that window's handshake.
- start while busy is ignored. s_valid outside RUN is ignored, with s_ready=0.
- Reset mid-frame abandons the frame; the layer's internal buffer state is not cleared, and the next frame overwrites it.

## Timing
- Reset values: state IDLE, s_ready 0, layer_clk_en 0, m_valid 0, m_data 0, m_last 0, busy 0, frame_done 0, pend 0, counters 0.
- s_ready rises the cycle after start is sampled in IDLE.
- Latency from acceptance of a qualifying pixel to m_valid is 2 cycles when the output slot is free: pend at edge 1, capture at edge 2.
- With s_valid=1 and m_ready=1 held, one pixel is accepted per cycle with no bubbles.
- With m_ready=0, at most one window is pending plus one held in m_data before s_ready drops.
- frame_done is asserted the cycle after the final m handshake (or after the final capture edge if m_ready is already high), with busy falling in the same cycle.

## Test plan
- IMAGE_SIZE=6, F=3, STRIDE=1, pixels 0..35 streamed, m_ready=1 -> 16 windows; the first m_valid is 2 cycles after pixel 14 is accepted, m_last falls on window 16, frame_done pulses once, and s_ready never drops.
- Same config with STRIDE=2 -> exactly 4 windows, at pixels 14, 16, 26 and 28; m_data equals layer_data sampled one cycle after each of these.
- m_ready=0 for 10 cycles after the first window -> s_ready falls after the second qualifying pixel; m_data holds window 1 and then window 2 unchanged; no pixel is lost; total still 16.
- Random s_valid and m_ready (50%) over 3 frames -> each frame yields exactly 16 windows in order, layer_clk_en pulses equal 36 per frame, and start during busy has no effect.
- rst_n low at pixel 20 -> all outputs return to reset values asynchronously; a following start and full frame yields a correct 16-window frame.
- F=IMAGE_SIZE=4, STRIDE=1 -> a single window at pixel 15, with m_last=1 on it.
